// File: rtl/crack_sequencer.sv
// crack_sequencer: feeds seeds to a phase-swept hash engine, tags each phase, logs hits into a result FIFO (option CRACK_SEQ_STOP_ON_HIT_EN ends the job at the first hit)
module crack_sequencer #(
  parameter int CSDIV = 16,
  parameter int LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [31:0]              job_count,
  input  logic [31:0]              goal_in,
  output logic                     busy,
  output logic                     done,
  input  logic                     seed_valid,
  input  logic [31:0]              seed_data,
  output logic                     seed_ready,
  output logic [31:0]              eng_seed,
  output logic [31:0]              eng_goal,
  output logic                     eng_reset_counter,
  input  logic                     eng_success,
  input  logic                     eng_next_initial,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_seed_idx,
  output logic [$clog2(CSDIV)-1:0] res_phase,
  output logic                     overflow
);
  localparam int PW = $clog2(CSDIV);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SWEEP, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] goal, count, seed_idx;
  logic [PW-1:0] phase;
  logic [DW-1:0] drain_cnt;
  logic hv [1:LAT];
  logic [31:0] hs [1:LAT];
  logic [PW-1:0] hp [1:LAT];
  logic [31:0] fs [FIFO_DEPTH];
  logic [PW-1:0] fp [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] fcnt;
  logic last_phase, last_seed, hit, pop, full, push, stop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign last_phase = phase == PW'(CSDIV - 1);
  assign last_seed = seed_idx == count - 32'd1;
  assign seed_ready = state == LOAD || (state == SWEEP && last_phase && !last_seed);
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign eng_reset_counter = state != SWEEP;
  assign eng_goal = goal;
  assign hit = eng_success && hv[LAT];
  assign res_valid = fcnt != '0;
  assign pop = res_valid && res_ready;
  assign full = fcnt == CW'(FIFO_DEPTH);
  assign push = hit && (!full || pop);
  assign res_seed_idx = fs[rp];
  assign res_phase = fp[rp];
`ifdef CRACK_SEQ_STOP_ON_HIT_EN
  assign stop = hit && (state == LOAD || state == SWEEP);
`else
  assign stop = 1'b0;
`endif

  // job sequencing: seed loading, phase sweep, drain of the engine latency tail
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      goal <= '0;
      count <= '0;
      seed_idx <= '0;
      phase <= '0;
      eng_seed <= '0;
      overflow <= 1'b0;
      drain_cnt <= '0;
    end else begin
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      if (hit && full && !pop) overflow <= 1'b1;
      case (state)
        IDLE: if (start) begin
          goal <= goal_in;
          count <= job_count;
          seed_idx <= '0;
          overflow <= 1'b0;
          state <= job_count == '0 ? DONE : LOAD;
        end
        LOAD: if (stop) state <= DRAIN;
        else if (seed_valid) begin
          eng_seed <= seed_data;
          phase <= '0;
          state <= SWEEP;
        end
        SWEEP: begin
          if (eng_next_initial != last_phase) overflow <= 1'b1;
          if (stop || (last_phase && last_seed)) state <= DRAIN;
          else if (!last_phase) phase <= phase + 1'b1;
          else begin
            seed_idx <= seed_idx + 32'd1;
            if (seed_valid) begin
              eng_seed <= seed_data;
              phase <= '0;
            end else state <= LOAD;
          end
        end
        DRAIN: if (drain_cnt == DW'(LAT - 1)) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // tag history aligned with engine latency; only sweep cycles carry a valid tag
  always_ff @(posedge clk) begin
    if (reset) for (int i = 1; i <= LAT; i++) hv[i] <= 1'b0;
    else begin
      hv[1] <= state == SWEEP;
      hs[1] <= seed_idx;
      hp[1] <= phase;
      for (int i = LAT; i > 1; i--) begin
        hv[i] <= hv[i-1];
        hs[i] <= hs[i-1];
        hp[i] <= hp[i-1];
      end
    end
  end

  // hit result FIFO, kept across jobs
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      fcnt <= '0;
    end else begin
      if (push) begin
        fs[wp] <= hs[LAT];
        fp[wp] <= hp[LAT];
        wp <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_crack_sequencer.sv
// tb_crack_sequencer: directed bench with a behavioural engine model and a result scoreboard
module tb_crack_sequencer;
  localparam int CSDIV = 16;
  localparam int LAT = 2;
  localparam logic [31:0] SB = 32'hA000_0000;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] job_count = 0, goal_in = 0, seed_data = SB;
  logic seed_valid = 0, res_ready = 0, force_succ = 0;
  logic busy, done, seed_ready, eng_reset_counter, eng_success, eng_next_initial, res_valid, overflow;
  logic [31:0] eng_seed, eng_goal, res_seed_idx;
  logic [3:0] res_phase;
  int n_vec = 0, n_err = 0, n_done = 0, n_busy = 0, n_sr = 0, n_load = 0, sidx = 0;
  int cnt = 0, ntgt = 0;
  logic [LAT-1:0] pipe = '0;
  logic [31:0] tgt_seed [8];
  int tgt_ph [8];
  logic [35:0] q [$];

  crack_sequencer #(.CSDIV(CSDIV), .LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .job_count(job_count), .goal_in(goal_in),
    .busy(busy), .done(done), .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
    .eng_seed(eng_seed), .eng_goal(eng_goal), .eng_reset_counter(eng_reset_counter),
    .eng_success(eng_success), .eng_next_initial(eng_next_initial), .res_valid(res_valid),
    .res_ready(res_ready), .res_seed_idx(res_seed_idx), .res_phase(res_phase), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic logic match();
    for (int i = 0; i < ntgt; i++) if (eng_seed == tgt_seed[i] && cnt == tgt_ph[i]) return 1'b1;
    return 1'b0;
  endfunction

  // engine model: free-running phase counter, success LAT cycles after a target seed/phase
  always @(posedge clk) begin
    cnt <= eng_reset_counter ? 0 : (cnt == CSDIV - 1 ? 0 : cnt + 1);
    pipe <= {pipe[LAT-2:0], !eng_reset_counter && match()};
  end
  assign eng_success = pipe[LAT-1] | force_succ;
  assign eng_next_initial = cnt == CSDIV - 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = seed_valid && seed_ready;
    if (done) n_done++;
    if (busy && !done) n_busy++;
    if (seed_ready) n_sr++;
    if (busy && seed_ready && eng_reset_counter) n_load++;
    if (res_valid && res_ready) begin
      chk("sb_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) chk("sb_result", 64'({res_seed_idx, res_phase}), 64'(q.pop_front()));
    end
    @(posedge clk);
    #1;
    if (acc) begin
      sidx++;
      seed_data = SB + 32'(sidx);
    end
  endtask

  task automatic add_tgt(input int idx, input int ph, input bit expect_res);
    tgt_seed[ntgt] = SB + 32'(idx);
    tgt_ph[ntgt] = ph;
    ntgt++;
    if (expect_res) q.push_back({32'(idx), 4'(ph)});
  endtask

  task automatic start_job(input int n, input logic [31:0] g);
    job_count = 32'(n);
    goal_in = g;
    sidx = 0;
    seed_data = SB;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (!done && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", 64'(done), 64'd1);
    tick();
  endtask

  initial begin
    int b0, d0, s0, l0, k, ns;
    logic [35:0] held;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_seed_ready", 64'(seed_ready), 0);
    chk("rst_eng_reset_counter", 64'(eng_reset_counter), 1);
    chk("rst_eng_seed", 64'(eng_seed), 0);
    chk("rst_eng_goal", 64'(eng_goal), 0);
    chk("rst_res_valid", 64'(res_valid), 0);
    chk("rst_overflow", 64'(overflow), 0);
    reset = 0;
    tick();
    // zero-seed job
    d0 = n_done; s0 = n_sr;
    start_job(0, 32'hDEAD_BEEF);
    chk("zero_done", 64'(done), 1);
    tick();
    chk("zero_done_pulse", 64'(done), 0);
    chk("zero_busy", 64'(busy), 0);
    chk("zero_done_count", 64'(n_done - d0), 1);
    chk("zero_seed_ready", 64'(n_sr - s0), 0);
    chk("zero_res_valid", 64'(res_valid), 0);
    chk("zero_goal", 64'(eng_goal), 64'hDEAD_BEEF);
    // three seeds back to back, one hit at seed 1 phase 5
    res_ready = 1; seed_valid = 1; ntgt = 0;
    add_tgt(1, 5, 1);
    b0 = n_busy; d0 = n_done; l0 = n_load;
    start_job(3, 32'h1234_5678);
    wait_done(200);
    chk("b2b_busy_cycles", 64'(n_busy - b0), 64'(1 + 3 * CSDIV + LAT));
    chk("b2b_done_count", 64'(n_done - d0), 1);
    chk("b2b_load_cycles", 64'(n_load - l0), 1);
    chk("b2b_overflow", 64'(overflow), 0);
    chk("b2b_goal", 64'(eng_goal), 64'h1234_5678);
    chk("b2b_sb_empty", 64'(q.size()), 0);
    // five hits into a stalled FIFO: first four kept, overflow set
    res_ready = 0; ntgt = 0;
    add_tgt(0, 1, 1); add_tgt(0, 3, 1); add_tgt(0, 5, 1); add_tgt(0, 7, 1); add_tgt(0, 9, 0);
    start_job(1, 32'h1);
    wait_done(100);
    chk("ovf_set", 64'(overflow), 1);
    chk("ovf_res_valid", 64'(res_valid), 1);
    held = {res_seed_idx, res_phase};
    tick(); tick();
    chk("ovf_hold", 64'({res_seed_idx, res_phase}), 64'(held));
    res_ready = 1;
    repeat (6) tick();
    chk("ovf_drained", 64'(res_valid), 0);
    chk("ovf_sb_empty", 64'(q.size()), 0);
    chk("ovf_sticky", 64'(overflow), 1);
    // pop and push on the same cycle while full
    res_ready = 0; ntgt = 0;
    add_tgt(0, 1, 1); add_tgt(0, 2, 1); add_tgt(0, 3, 1); add_tgt(0, 4, 1); add_tgt(0, 10, 1);
    start_job(1, 32'h2);
    chk("start_clears_ovf", 64'(overflow), 0);
    k = 0; ns = 0;
    while (!done && k < 100) begin
      tick();
      k++;
      if (eng_success) ns++;
      res_ready = eng_success && ns == 5;
    end
    chk("simul_done", 64'(done), 1);
    chk("simul_no_ovf", 64'(overflow), 0);
    res_ready = 1;
    repeat (6) tick();
    chk("simul_drained", 64'(res_valid), 0);
    chk("simul_sb_empty", 64'(q.size()), 0);
    // seed bubble: LOAD between seeds, success during the bubble ignored
    ntgt = 0;
    add_tgt(1, 0, 1);
    seed_valid = 1;
    start_job(2, 32'h3);
    tick();
    seed_valid = 0;
    k = 0;
    while (!(busy && seed_ready && eng_reset_counter) && k < 40) begin
      tick();
      k++;
    end
    chk("bubble_load", 64'(busy && seed_ready && eng_reset_counter), 1);
    repeat (3) tick();
    chk("bubble_still_load", 64'(eng_reset_counter && seed_ready), 1);
    force_succ = 1;
    tick();
    force_succ = 0;
    seed_valid = 1;
    wait_done(100);
    repeat (4) tick();
    chk("bubble_overflow", 64'(overflow), 0);
    chk("bubble_res_valid", 64'(res_valid), 0);
    chk("bubble_sb_empty", 64'(q.size()), 0);
    // hit on seed 0 of a four-seed job
    ntgt = 0;
    add_tgt(0, 3, 1);
    b0 = n_busy;
    start_job(4, 32'h4);
    wait_done(300);
    repeat (4) tick();
`ifdef CRACK_SEQ_STOP_ON_HIT_EN
    chk("stop_busy_cycles", 64'(n_busy - b0), 64'(1 + (3 + LAT + 1) + LAT));
`else
    chk("full_busy_cycles", 64'(n_busy - b0), 64'(1 + 4 * CSDIV + LAT));
`endif
    chk("hit0_sb_empty", 64'(q.size()), 0);
    // reset mid-sweep: no done, FIFO and in-flight hits discarded
    res_ready = 0; ntgt = 0;
    add_tgt(0, 2, 0); add_tgt(0, 10, 0);
    start_job(2, 32'h5);
    repeat (11) tick();
    chk("mid_busy", 64'(busy), 1);
    chk("mid_res_valid", 64'(res_valid), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_res_valid", 64'(res_valid), 0);
    d0 = n_done;
    res_ready = 1;
    repeat (40) tick();
    chk("abort_no_done", 64'(n_done - d0), 0);
    chk("abort_res_empty", 64'(res_valid), 0);
    chk("abort_overflow", 64'(overflow), 0);
    chk("final_sb_empty", 64'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
